// File: rtl/tcount_decoder.sv
`timescale 1ns/1ps
// Purpose : decodes a sampled thermometer count to a binary level and checks counter progression.
// Latency : one cycle; a sample on edge k shows on LEVEL/VALID after edge k.
// Backpres: none; every EN=1 cycle is evaluated, and EN=0 holds all state.
//
// Ports:
//   CLK, RESET       rising-edge clock, asynchronous active-high reset
//   EN, T            sample strobe and thermometer code (bit 0 fills first)
//   CLR_ERR          synchronous clear of sticky flags; returns FSM to IDLE
//   LEVEL, VALID     last accepted binary level and its one-cycle update pulse
//   ILLEGAL, SEQERR  sticky flags: non-thermometer code / illegal level step
//   WRAPS            count of legal WIDTH->0 steps, modulo 2^WRAP_W
//   STATE            FSM state: 00 IDLE, 01 TRACK, 10 ERR
//
// Optional build macro TCOUNT_DECODER_BUBBLE_FIX_EN: non-thermometer codes are
// bubble-corrected (level = popcount) and tracked normally; ILLEGAL still sticks.
module tcount_decoder #(
  parameter int WIDTH  = 4,
  parameter int LVL_W  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [WIDTH-1:0]  T,
  input  logic              CLR_ERR,
  output logic [LVL_W-1:0]  LEVEL,
  output logic              VALID,
  output logic              ILLEGAL,
  output logic              SEQERR,
  output logic [WRAP_W-1:0] WRAPS,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_ERR   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  localparam logic [LVL_W-1:0] FULL = LVL_W'(WIDTH);

  state_t            state_q, state_nx;
  logic [LVL_W-1:0]  level_nx;
  logic              valid_nx, illegal_nx, seqerr_nx;
  logic [WRAP_W-1:0] wraps_nx;

  logic [LVL_W-1:0]  pop;
  logic [WIDTH:0]    t_ext;
  logic              is_therm;
  logic              accept;
  logic              step_hold, step_inc, step_wrap;

  // A legal code is 0..01..1, so T+1 is a power of two and shares no bit with T.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + LVL_W'(T[i]);
    end
    t_ext    = {1'b0, T};
    is_therm = ((t_ext & (t_ext + (WIDTH+1)'(1))) == '0);
  end

`ifdef TCOUNT_DECODER_BUBBLE_FIX_EN
  assign accept = 1'b1;
`else
  assign accept = is_therm;
`endif

  // Increment is compared one bit wider so p+1 cannot alias to 0 at full scale.
  assign step_hold = (pop == LEVEL);
  assign step_inc  = ({1'b0, pop} == ({1'b0, LEVEL} + (LVL_W+1)'(1)));
  assign step_wrap = (LEVEL == FULL) && (pop == '0);

  always_comb begin
    state_nx   = state_q;
    level_nx   = LEVEL;
    valid_nx   = 1'b0;
    illegal_nx = ILLEGAL;
    seqerr_nx  = SEQERR;
    wraps_nx   = WRAPS;

    case (state_q)
      S_IDLE: begin
        if (EN) begin
          if (!is_therm) illegal_nx = 1'b1;
          if (accept) begin
            level_nx = pop;
            valid_nx = 1'b1;
            state_nx = S_TRACK;
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_TRACK: begin
        if (EN) begin
          if (!is_therm) illegal_nx = 1'b1;
          if (accept) begin
            level_nx = pop;
            valid_nx = 1'b1;
            if (step_wrap) begin
              wraps_nx = WRAPS + WRAP_W'(1);
            end else if (!(step_hold || step_inc)) begin
              seqerr_nx = 1'b1;
              state_nx  = S_ERR;
            end
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      S_ERR: begin
        // Keep decoding so downstream still sees the level, but stop judging steps.
        if (EN) begin
          if (!is_therm) illegal_nx = 1'b1;
          if (accept) begin
            level_nx = pop;
            valid_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Clear wins over the flag/state effects of a same-cycle sample only.
    if (CLR_ERR) begin
      illegal_nx = 1'b0;
      seqerr_nx  = 1'b0;
      state_nx   = S_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      LEVEL   <= '0;
      VALID   <= 1'b0;
      ILLEGAL <= 1'b0;
      SEQERR  <= 1'b0;
      WRAPS   <= '0;
    end else begin
      state_q <= state_nx;
      LEVEL   <= level_nx;
      VALID   <= valid_nx;
      ILLEGAL <= illegal_nx;
      SEQERR  <= seqerr_nx;
      WRAPS   <= wraps_nx;
    end
  end

  assign STATE = state_q;

endmodule

// File: doc/tcount_decoder.md
Name: tcount_decoder

Overview:
- Receive-side companion to the thermometer counter; this is its decoder.
- Samples a thermometer-coded count bus on a strobe, converts it to binary level and checks each step against legal counter progression.
- Counts completed wraps (full-scale back to zero) and reports illegal codes and sequence errors through a small FSM.
- Sits between a thermometer-coded counter output and binary datapath or debug logic.

Parameters:
WIDTH, 4, number of thermometer bits; legal levels 0..WIDTH
LVL_W, 3, width of binary LEVEL output; must satisfy 2^LVL_W > WIDTH
WRAP_W, 8, width of wrap counter

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous active-high reset
EN  input  1  sample strobe; T is evaluated only when EN=1
T  input  WIDTH  thermometer-coded count; bit 0 fills first
CLR_ERR  input  1  synchronous clear of the error state and sticky flags
LEVEL  output  LVL_W  registered binary level of last accepted code
VALID  output  1  one-cycle pulse: LEVEL updated this cycle
ILLEGAL  output  1  sticky: a non-thermometer code was sampled
SEQERR  output  1  sticky: an illegal level step was sampled
WRAPS  output  WRAP_W  count of legal WIDTH->0 transitions, wraps modulo 2^WRAP_W
STATE  output  2  FSM state: 00 IDLE, 01 TRACK, 10 ERR

Behaviour:
- Reset (async, RESET=1): LEVEL=0, VALID=0, ILLEGAL=0, SEQERR=0, WRAPS=0, STATE=IDLE. Reset mid-operation discards all history.
- Legal code: T = 0...01...1 (contiguous ones from bit 0, including all-zero and all-one). Level = number of ones.
- Latency: a sample taken on edge k produces LEVEL/VALID after edge k (visible in cycle k+1). VALID is high exactly one cycle per accepted sample.
- EN=0: no state change, VALID=0, flags and LEVEL hold.
- IDLE, EN=1:
  - Legal code: LEVEL<=level, VALID=1, go to TRACK. No step check on this first sample.
  - Illegal code: ILLEGAL<=1, go to ERR, LEVEL holds.
- TRACK, EN=1, with p = previous LEVEL and n = new level:
  - Legal steps are n==p (hold), n==p+1 (count), or p==WIDTH and n==0 (wrap).
  - Legal step: LEVEL<=n, VALID=1. On a wrap, WRAPS<=WRAPS+1 (rolls over at max).
  - Legal code but illegal step (skip, decrement, or wrap to nonzero): SEQERR<=1, LEVEL<=n, VALID=1, go to ERR.
  - Illegal code: ILLEGAL<=1, LEVEL holds, VALID=0, go to ERR.
- ERR: samples are still decoded. LEVEL and VALID update for legal codes, with no step checks and no WRAPS increments. Illegal codes re-assert ILLEGAL.
- CLR_ERR=1, any state: ILLEGAL<=0, SEQERR<=0, go to IDLE. CLR_ERR takes priority over a simultaneous EN sample's flag/state effects; LEVEL/VALID still update if the code is legal. WRAPS is not cleared.
- Simultaneous legal wrap and CLR_ERR in TRACK: WRAPS increments; state goes IDLE.
- STATE encoding 11 is unused; it recovers to IDLE on the next edge.

Optional Feature:
- Macro: TCOUNT_DECODER_BUBBLE_FIX_EN.
- Defined: non-thermometer codes are bubble-corrected; level = population count of T. ILLEGAL is still set (sticky) but does not force ERR. The corrected level goes through normal step checking, and VALID pulses.
- Undefined: behaviour exactly as in Behaviour; illegal codes never update LEVEL.

Test Plan:
- Reset then EN=1 with T = 0000,0001,0011,0111,1111,0000 on consecutive cycles -> LEVEL 0,1,2,3,4,0 with VALID each cycle, WRAPS=1, STATE=TRACK, ILLEGAL=SEQERR=0.
- TRACK at LEVEL=1, sample T=0111 -> LEVEL=3, SEQERR=1, STATE=ERR; then CLR_ERR=1 -> SEQERR=0, STATE=IDLE, WRAPS unchanged.
- Sample T=0101 in TRACK at LEVEL=2 -> ILLEGAL=1, LEVEL stays 2, VALID=0, STATE=ERR. With TCOUNT_DECODER_BUBBLE_FIX_EN: LEVEL=2, VALID=1, ILLEGAL=1, STATE=TRACK.
- EN toggling 1,0,0,1 with T=0011 then 0111 -> VALID only on the EN cycles, LEVEL 2 then 3, no SEQERR.
- Drive 256 full cycles of 0..4 with WRAP_W=8 -> WRAPS rolls from 255 to 0; assert RESET asynchronously mid-cycle (between edges) -> all outputs zero immediately, STATE=IDLE.
- IDLE, first sample T=0111 -> LEVEL=3, VALID=1, no SEQERR, STATE=TRACK.
